// File: rtl/zbus_fifo_reg.sv
// zbus_fifo_reg: register-array FIFO between a zbus producer (zi_*) and a
// zbus consumer (zo_*), single clock domain. Depth LN words of BW bits.
// Full/empty flags are registered from the next-state pointers, so zi_ack
// and zo_vld have no combinational path from zi_vld or zo_ack. The head
// word is read straight from the storage array.
//
// Optional feature: define ZBUS_FIFO_CNT_EN to add the z_cnt output, a
// registered occupancy count (0..LN).
module zbus_fifo_reg #(
    parameter int BW = 8,
    parameter int LN = 4
) (
    input  logic          z_clk,
    input  logic          z_rst,
    input  logic          zi_vld,
    input  logic [BW-1:0] zi_bus,
    output logic          zi_ack,
    output logic          zo_vld,
    output logic [BW-1:0] zo_bus,
    input  logic          zo_ack
`ifdef ZBUS_FIFO_CNT_EN
    ,
    output logic [$clog2(LN):0] z_cnt
`endif
);

    localparam int AW = $clog2(LN);

    // Pointers carry one extra MSB used as a wrap flag to tell full from empty.
    logic [AW:0]   wp, rp;
    logic [AW:0]   wp_nxt, rp_nxt;
    logic          empty, full;
    logic          zi_trn, zo_trn;
    logic [BW-1:0] mem [LN];

    assign zi_trn = zi_vld & zi_ack;
    assign zo_trn = zo_vld & zo_ack;

    assign zi_ack = ~full;
    assign zo_vld = ~empty;
    assign zo_bus = mem[rp[AW-1:0]];

    // Next-state pointers: advance on each side's handshake.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        wp_nxt = wp;
        rp_nxt = rp;
        if (zi_trn) wp_nxt = wp + (AW+1)'(1);
        if (zo_trn) rp_nxt = rp + (AW+1)'(1);
    end

    // Pointer and flag registers; reset wins over any concurrent transfer.
    always_ff @(posedge z_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (z_rst) begin
            wp    <= '0;
            rp    <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wp    <= wp_nxt;
            rp    <= rp_nxt;
            empty <= (wp_nxt == rp_nxt);
            full  <= (wp_nxt[AW-1:0] == rp_nxt[AW-1:0]) && (wp_nxt[AW] != rp_nxt[AW]);
        end
    end

    // Storage write; a word offered during reset is dropped.
    always_ff @(posedge z_clk) begin
        // NOTE: the array has no reset; the pointers alone decide which entries are valid.
        if (zi_trn && !z_rst) mem[wp[AW-1:0]] <= zi_bus;
    end

`ifdef ZBUS_FIFO_CNT_EN
    logic [AW:0] cnt;

    // Occupancy counter: +1 on write only, -1 on read only.
    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            cnt <= '0;
        end else begin
            case ({zi_trn, zo_trn})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign z_cnt = cnt;
`endif

endmodule

// File: tb/tb_zbus_fifo_reg.sv
// tb_zbus_fifo_reg: directed plus randomized stimulus for zbus_fifo_reg,
// compared every cycle against a queue-based FIFO model.
module tb_zbus_fifo_reg;

    localparam int BW = 8;
    localparam int LN = 4;

    logic          z_clk = 1'b0;
    logic          z_rst = 1'b0;
    logic          zi_vld = 1'b0;
    logic [BW-1:0] zi_bus = '0;
    logic          zi_ack;
    logic          zo_vld;
    logic [BW-1:0] zo_bus;
    logic          zo_ack = 1'b0;
`ifdef ZBUS_FIFO_CNT_EN
    logic [$clog2(LN):0] z_cnt;
`endif

    zbus_fifo_reg #(.BW(BW), .LN(LN)) dut (
        .z_clk  (z_clk),
        .z_rst  (z_rst),
        .zi_vld (zi_vld),
        .zi_bus (zi_bus),
        .zi_ack (zi_ack),
        .zo_vld (zo_vld),
        .zo_bus (zo_bus),
        .zo_ack (zo_ack)
`ifdef ZBUS_FIFO_CNT_EN
        ,
        .z_cnt  (z_cnt)
`endif
    );

    always #5 z_clk = ~z_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: ordered list of words currently held.
    logic [BW-1:0] q[$];
    int            rd_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("zo_vld", {31'd0, zo_vld}, {31'd0, q.size() != 0});
        check("zi_ack", {31'd0, zi_ack}, {31'd0, q.size() < LN});
        if (q.size() != 0) check("zo_bus", {24'd0, zo_bus}, {24'd0, q[0]});
`ifdef ZBUS_FIFO_CNT_EN
        check("z_cnt", 32'(z_cnt), 32'(q.size()));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, update the model, check.
    task automatic step(input logic vld, input logic [BW-1:0] bus, input logic ack,
                        input logic rst, output logic wr);
        logic rd;
        zi_vld = vld;
        zi_bus = bus;
        zo_ack = ack;
        z_rst  = rst;
        wr = vld && (q.size() < LN);
        rd = ack && (q.size() != 0);
        @(posedge z_clk);
        if (rst) begin
            q.delete();
            wr = 1'b0;
        end else begin
            if (rd) begin
                void'(q.pop_front());
                rd_count++;
            end
            if (wr) q.push_back(bus);
        end
        @(negedge z_clk);
        check_outputs();
    endtask

    initial begin
        logic          wr;
        logic [BW-1:0] nxt;
        int            n;

        // Reset, two cycles.
        step(1'b0, '0, 1'b0, 1'b1, wr);
        step(1'b0, '0, 1'b0, 1'b1, wr);
        check("rst_zo_vld", {31'd0, zo_vld}, 32'd0);
        check("rst_zi_ack", {31'd0, zi_ack}, 32'd1);

        // Streaming 0..18 with the consumer always ready.
        rd_count = 0;
        nxt = 8'd0;
        n = 0;
        while (nxt != 8'd19 && n < 60) begin
            step(1'b1, nxt, 1'b1, 1'b0, wr);
            if (wr) nxt++;
            else check("stream_stall", 32'd0, 32'd1);
            n++;
        end
        check("stream_words", 32'(nxt), 32'd19);
        step(1'b0, '0, 1'b1, 1'b0, wr);
        check("stream_reads", 32'(rd_count), 32'd19);

        // Fill: consumer stalled, source offers 10..14.
        nxt = 8'd10;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, nxt, 1'b0, 1'b0, wr);
            if (wr) nxt++;
        end
        check("fill_accepted", 32'(nxt), 32'd14);
        check("fill_full", {31'd0, zi_ack}, 32'd0);
        check("fill_head", {24'd0, zo_bus}, 32'd10);

        // Drain from full while the source keeps offering 14.
        for (int i = 0; i < 4; i++) begin
            step(nxt == 8'd14, nxt, 1'b1, 1'b0, wr);
            if (wr) nxt++;
        end
        check("drain_14_taken", 32'(nxt), 32'd15);
        check("drain_last", {24'd0, zo_bus}, 32'd14);
        step(1'b0, '0, 1'b1, 1'b0, wr);
        check("drain_empty", {31'd0, zo_vld}, 32'd0);

        // Simultaneous read/write at occupancy 2, across pointer wrap.
        step(1'b1, 8'h40, 1'b0, 1'b0, wr);
        step(1'b1, 8'h41, 1'b0, 1'b0, wr);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h42 + i), 1'b1, 1'b0, wr);
            check("simul_occ", 32'(q.size()), 32'd2);
        end
        check("simul_head", {24'd0, zo_bus}, 32'h48);
        step(1'b0, '0, 1'b1, 1'b0, wr);
        step(1'b0, '0, 1'b1, 1'b0, wr);

        // Empty boundary: one write of 0xA5.
        zi_vld = 1'b1;
        zi_bus = 8'hA5;
        zo_ack = 1'b0;
        #1;
        check("empty_same_cycle", {31'd0, zo_vld}, 32'd0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, wr);
        check("empty_next_vld", {31'd0, zo_vld}, 32'd1);
        check("empty_next_bus", {24'd0, zo_bus}, 32'hA5);
        step(1'b0, '0, 1'b1, 1'b0, wr);
        check("empty_after_read", {31'd0, zo_vld}, 32'd0);

        // Reset mid-operation with a concurrent write.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, wr);
        step(1'b1, 8'h77, 1'b0, 1'b1, wr);
        check("midrst_zo_vld", {31'd0, zo_vld}, 32'd0);
        check("midrst_zi_ack", {31'd0, zi_ack}, 32'd1);
`ifdef ZBUS_FIFO_CNT_EN
        check("midrst_cnt", 32'(z_cnt), 32'd0);
`endif
        step(1'b1, 8'h33, 1'b0, 1'b0, wr);
        check("midrst_first", {24'd0, zo_bus}, 32'h33);
        step(1'b0, '0, 1'b1, 1'b0, wr);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0), wr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
